ifft_stream_sink: RTL and testbench
===================================

Name: ifft_stream_sink

Overview:
Consumer at the output end of the pipelined inverse-FFT core. It takes the core's clock-enabled result stream (ce / sync / result), aligns to frame boundaries and buffers samples in a small synchronous FIFO. It presents the samples on a valid/ready stream with first/last frame markers. It also raises a stall request that upstream logic uses to gate the FFT's clock enable, so no sample is lost under downstream backpressure.

Parameters:
DW, 32, sample width (real in high DW/2 bits, imaginary in low DW/2), passed through unchanged
LGSIZE, 11, log2 of FFT frame length; frame = 2^LGSIZE samples
LGFIFO, 5, log2 of FIFO depth
AFULL_MARGIN, 4, o_stall asserts when fill >= 2^LGFIFO - AFULL_MARGIN; must cover upstream ce-gating latency

Ports:
i_clk  in  1  clock; the only clock
i_reset  in  1  synchronous, active-high reset
i_ce  in  1  one FFT output sample is valid this cycle
i_sync  in  1  qualifies i_ce: current sample is index 0 of a frame
i_result  in  DW  FFT output sample
o_stall  out  1  registered request to upstream to deassert FFT i_ce
o_valid  out  1  o_data/o_first/o_last valid
i_ready  in  1  downstream accepts when o_valid && i_ready
o_data  out  DW  buffered sample
o_first  out  1  sample is index 0 of frame
o_last  out  1  sample is index 2^LGSIZE-1 of frame
o_overflow  out  1  sticky: a sample arrived with FIFO full and no pop
o_sync_err  out  1  sticky: i_sync seen at nonzero frame index

Behaviour:
- Interface is one clock (i_clk); reset is synchronous and active-high (i_reset).
- Reset values:
  - o_valid=0, o_stall=0, o_overflow=0, o_sync_err=0
  - FIFO empty, frame index=0, FSM=WAIT_SYNC
  - o_data/o_first/o_last are don't-care while o_valid=0
- Reset asserted mid-frame discards all buffered data.
- FSM states:
  - WAIT_SYNC: samples with i_ce && !i_sync are discarded. On i_ce && i_sync: push the sample with first=1, set index=1, go to RUN.
  - RUN, each i_ce: push {first=(index==0), last=(index==2^LGSIZE-1), i_result}. Index increments modulo 2^LGSIZE, wrapping to 0 after last.
  - RUN, i_ce && i_sync with index!=0: set o_sync_err. The sample is pushed as first=1, index=1 (resync). The preceding partial frame is not padded and carries no o_last.
  - RUN, i_ce && i_sync with index==0: normal frame start.
- Overflow:
  - Condition: i_ce while FIFO full and no pop in the same cycle.
  - Response: the sample is dropped, o_overflow is set, FSM goes to WAIT_SYNC, index=0. Output resumes only at the next full frame start.
- Simultaneous push and pop: allowed at any fill level, including full (the pop frees the slot); fill is unchanged.
- FIFO is show-ahead. A push into an empty FIFO at edge N gives o_valid=1 after edge N (latency 1 cycle). o_data is stable while o_valid && !i_ready.
- o_stall is registered from the next-state fill (fill_next >= 2^LGFIFO - AFULL_MARGIN) and deasserts when below. It is advisory; i_ce arriving while stalled is still accepted if space exists.
- No gaps or reordering are introduced; throughput is 1 sample/cycle when i_ready stays high.
- Sticky flags clear only on i_reset.

Decomposition:
- Shared package (ifft_pkg): FIFO entry layout {first, last, data} with width DW+2; FSM state encoding WAIT_SYNC/RUN.
- Sub-module ifft_sink_fifo: synchronous show-ahead FIFO, parameters WIDTH and LGDEPTH.
  - Ports: push, pop, wdata, rdata, empty, full, fill.
  - Pointers are LGDEPTH+1 bits wide.
- Top level holds the FSM, index counter, flags and stall logic.

Test Plan:
- LGSIZE=3, i_ready=1, continuous i_ce, i_sync every 8 samples, data=index -> o_valid starts 1 cycle after first push; o_first on data 0, o_last on data 7; exactly 8 samples per frame; no flags set.
- Three i_ce samples with i_sync=0 before the first sync -> those 3 samples never appear at the output; the first output sample has o_first=1.
- i_ready=0 with continuous i_ce, LGFIFO=5, AFULL_MARGIN=4 -> o_stall=1 from the cycle after fill reaches 28. Pushes 29-32 are accepted; the 33rd sets o_overflow. Output then resumes at the next i_sync with o_first=1.
- FIFO full, i_ce and i_ready both high in the same cycle -> no overflow; fill stays 32; the popped word is the oldest entry.
- i_sync at index 5 (LGSIZE=3) -> o_sync_err=1; that sample is output with o_first=1; the next o_last occurs 7 samples later.
- i_reset pulsed with 10 words buffered -> next cycle o_valid=0, flags=0, o_stall=0; old data is never output.

Source files
------------

// File: rtl/ifft_pkg.sv
// Shared definitions for the inverse-FFT output sink: FSM encoding and FIFO entry layout.
// Entry layout is {first, last, data}, so an entry is DW + ENTRY_TAG_W bits wide.
package ifft_pkg;

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } sink_state_t;

    localparam int ENTRY_TAG_W = 2;

    function automatic int entry_width(input int dw);
        return dw + ENTRY_TAG_W;
    endfunction

endpackage

// File: rtl/ifft_sink_fifo.sv
// Synchronous show-ahead FIFO: rdata shows the oldest entry whenever !empty.
// The caller must only push when !full or when popping in the same cycle.
module ifft_sink_fifo #(
    parameter int WIDTH   = 34,
    parameter int LGDEPTH = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic               empty,
    output logic               full,
    output logic [LGDEPTH:0]   fill
);
    localparam int DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LGDEPTH:0] wr_ptr_q, wr_ptr_d;
    logic [LGDEPTH:0] rd_ptr_q, rd_ptr_d;
    logic             do_pop;

    assign fill   = wr_ptr_q - rd_ptr_q;
    assign empty  = (fill == '0);
    // Fill never exceeds DEPTH, so the MSB alone marks full.
    assign full   = fill[LGDEPTH];
    assign do_pop = pop && !empty;
    assign rdata  = mem_q[rd_ptr_q[LGDEPTH-1:0]];

    assign wr_ptr_d = push   ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[LGDEPTH-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ifft_stream_sink.sv
// Frame-aligning sink for the IFFT result stream: buffers samples and emits a valid/ready
// stream with first/last markers, plus a registered stall request for FFT ce gating.
module ifft_stream_sink
    import ifft_pkg::*;
#(
    parameter int DW           = 32,
    parameter int LGSIZE       = 11,
    parameter int LGFIFO       = 5,
    parameter int AFULL_MARGIN = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_sync,
    input  logic [DW-1:0] i_result,
    output logic          o_stall,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_first,
    output logic          o_last,
    output logic          o_overflow,
    output logic          o_sync_err
);
    localparam int EW    = entry_width(DW);
    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0] AFULL_LVL = (LGFIFO + 1)'(DEPTH - AFULL_MARGIN);
    localparam logic [LGFIFO:0] FILL_ONE  = 1;
    localparam logic [LGSIZE-1:0] IDX_ONE  = 1;
    localparam logic [LGSIZE-1:0] IDX_LAST = '1;

    sink_state_t       state_q, state_d;
    logic [LGSIZE-1:0] idx_q, idx_d, eff_idx;
    logic              ovf_q, ovf_d;
    logic              serr_q, serr_d;
    logic              stall_q, stall_d;
    logic              push, pop, space;
    logic              empty, full;
    logic [LGFIFO:0]   fill, fill_next;
    logic [EW-1:0]     entry_w, entry_r;

    ifft_sink_fifo #(
        .WIDTH   (EW),
        .LGDEPTH (LGFIFO)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (push),
        .pop     (pop),
        .wdata   (entry_w),
        .rdata   (entry_r),
        .empty   (empty),
        .full    (full),
        .fill    (fill)
    );

    assign o_valid = !empty;
    assign pop     = o_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign space   = !full || pop;

    // A sync always restarts the frame, whatever the running index says.
    assign eff_idx = i_sync ? '0 : idx_q;
    assign entry_w = {(eff_idx == '0), (eff_idx == IDX_LAST), i_result};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        serr_d  = serr_q;
        push    = 1'b0;
        if (i_ce) begin
            if (i_sync && (state_q == RUN) && (idx_q != '0)) begin
                serr_d = 1'b1;
            end
            if (!space) begin
                ovf_d   = 1'b1;
                state_d = WAIT_SYNC;
                idx_d   = '0;
            end else if ((state_q == RUN) || i_sync) begin
                push    = 1'b1;
                state_d = RUN;
                idx_d   = eff_idx + IDX_ONE;
            end
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   fill_next = fill + FILL_ONE;
            2'b01:   fill_next = fill - FILL_ONE;
            default: fill_next = fill;
        endcase
        stall_d = (fill_next >= AFULL_LVL);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= WAIT_SYNC;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
            stall_q <= stall_d;
        end
    end

    assign o_data     = entry_r[DW-1:0];
    assign o_last     = entry_r[DW];
    assign o_first    = entry_r[DW+1];
    assign o_stall    = stall_q;
    assign o_overflow = ovf_q;
    assign o_sync_err = serr_q;

endmodule

// File: tb/tb_ifft_stream_sink.sv
// Directed bench for ifft_stream_sink with a queue scoreboard and a negedge monitor.
module tb_ifft_stream_sink;
    localparam int DW     = 32;
    localparam int LGSIZE = 3;
    localparam int LGFIFO = 5;
    localparam int MARGIN = 4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_ce;
    logic          i_sync;
    logic [DW-1:0] i_result;
    logic          o_stall;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_first;
    logic          o_last;
    logic          o_overflow;
    logic          o_sync_err;

    always #5 i_clk = ~i_clk;

    ifft_stream_sink #(
        .DW           (DW),
        .LGSIZE       (LGSIZE),
        .LGFIFO       (LGFIFO),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_sync     (i_sync),
        .i_result   (i_result),
        .o_stall    (o_stall),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_first    (o_first),
        .o_last     (o_last),
        .o_overflow (o_overflow),
        .o_sync_err (o_sync_err)
    );

    logic [DW+1:0] exp_q [$];
    logic [DW+1:0] exp_word;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word must match the oldest expected word.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data 0x%0h first %0b last %0b, expected no output",
                             o_data, o_first, o_last);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("out_word{first,last,data}", {30'd0, o_first, o_last, o_data}, {30'd0, exp_word});
                end
            end
        end
    end

    task automatic send(input logic sync, input logic [DW-1:0] d, input bit keep, input bit f, input bit l);
        i_ce     = 1'b1;
        i_sync   = sync;
        i_result = d;
        if (keep) exp_q.push_back({f, l, d});
        @(posedge i_clk);
        #1;
        i_ce   = 1'b0;
        i_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
        idle(2);
        check("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_ce     = 1'b0;
        i_sync   = 1'b0;
        i_result = '0;
        i_ready  = 1'b0;
        idle(3);
        i_reset = 1'b0;
        check("reset_valid", o_valid, 0);
        check("reset_stall", o_stall, 0);
        check("reset_overflow", o_overflow, 0);
        check("reset_sync_err", o_sync_err, 0);

        // Pre-sync samples are discarded, then two clean frames.
        i_ready = 1'b1;
        send(1'b0, 32'hAA, 0, 0, 0);
        send(1'b0, 32'hAB, 0, 0, 0);
        send(1'b0, 32'hAC, 0, 0, 0);
        check("presync_no_valid", o_valid, 0);
        send(1'b1, 32'h0, 1, 1, 0);
        check("first_push_latency", o_valid, 1);
        for (int n = 1; n < 8; n++) send(1'b0, 32'(n), 1, 0, n == 7);
        for (int n = 0; n < 8; n++) send(n == 0, 32'(n), 1, n == 0, n == 7);
        wait_drain();
        check("frames_overflow", o_overflow, 0);
        check("frames_sync_err", o_sync_err, 0);

        // Early sync at index 5 restarts the frame.
        for (int n = 0; n < 5; n++) send(n == 0, 32'h10 + 32'(n), 1, n == 0, 0);
        check("sync_err_before", o_sync_err, 0);
        send(1'b1, 32'h20, 1, 1, 0);
        check("sync_err_set", o_sync_err, 1);
        for (int n = 1; n < 8; n++) send(1'b0, 32'h20 + 32'(n), 1, 0, n == 7);
        wait_drain();
        check("sync_err_sticky", o_sync_err, 1);
        check("sync_err_no_overflow", o_overflow, 0);

        // Backpressure: fill to full, push+pop at full, then overflow and resync.
        i_ready = 1'b0;
        for (int n = 0; n < 32; n++) begin
            send(n % 8 == 0, 32'h100 + 32'(n), 1, n % 8 == 0, n % 8 == 7);
            if (n == 26) check("stall_at_fill27", o_stall, 0);
            if (n == 27) check("stall_at_fill28", o_stall, 1);
        end
        check("full_no_overflow", o_overflow, 0);
        i_ready = 1'b1;
        send(1'b1, 32'h120, 1, 1, 0);
        i_ready = 1'b0;
        check("push_pop_full_no_overflow", o_overflow, 0);
        check("push_pop_full_stall", o_stall, 1);
        send(1'b0, 32'h121, 0, 0, 0);
        check("overflow_set", o_overflow, 1);
        i_ready = 1'b1;
        for (int n = 2; n < 8; n++) send(1'b0, 32'h120 + 32'(n), 0, 0, 0);
        for (int n = 0; n < 8; n++) send(n == 0, 32'h200 + 32'(n), 1, n == 0, n == 7);
        wait_drain();
        check("overflow_sticky", o_overflow, 1);
        check("stall_released", o_stall, 0);

        // Reset with buffered data discards it and clears flags.
        i_ready = 1'b0;
        for (int n = 0; n < 10; n++) send(n == 0, 32'h300 + 32'(n), 0, 0, 0);
        check("buffered_valid", o_valid, 1);
        i_reset = 1'b1;
        idle(1);
        i_reset = 1'b0;
        check("midreset_valid", o_valid, 0);
        check("midreset_overflow", o_overflow, 0);
        check("midreset_sync_err", o_sync_err, 0);
        check("midreset_stall", o_stall, 0);
        i_ready = 1'b1;
        idle(20);
        check("post_reset_idle_valid", o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
